// File: rtl/dot_product_sequencer.sv
// Time-multiplexed unsigned dot product: one shared multiplier and accumulator step through N lanes.
// Define DOT_SEQ_SAT_EN to clamp the accumulator on overflow and report it on out_ovf.
module dot_product_sequencer #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned N         = 4,
  parameter int unsigned ACC_WIDTH = 2*BIT_WIDTH + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_WIDTH-1:0] a [N-1:0],
  input  logic [BIT_WIDTH-1:0] b [N-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);
  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned PROD_W = 2*BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [BIT_WIDTH-1:0]   a_r_q [N-1:0];
  logic [BIT_WIDTH-1:0]   a_r_d [N-1:0];
  logic [BIT_WIDTH-1:0]   b_r_q [N-1:0];
  logic [BIT_WIDTH-1:0]   b_r_d [N-1:0];
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic [PROD_W-1:0]      prod;

`ifdef DOT_SEQ_SAT_EN
  localparam int unsigned SUM_W = ACC_WIDTH + 1;
  logic             ovf_q, ovf_d;
  logic [SUM_W-1:0] sum;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    prod    = {{BIT_WIDTH{1'b0}}, a_r_q[idx_q]} * {{BIT_WIDTH{1'b0}}, b_r_q[idx_q]};
`ifdef DOT_SEQ_SAT_EN
    ovf_d   = ovf_q;
    sum     = {1'b0, acc_q} + SUM_W'(prod);
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_r_d   = a;
          b_r_d   = b;
          acc_d   = '0;
          idx_d   = '0;
`ifdef DOT_SEQ_SAT_EN
          ovf_d   = 1'b0;
`endif
          state_d = MAC;
        end
      end
      MAC: begin
`ifdef DOT_SEQ_SAT_EN
        // Once clamped, the accumulator stays at all-ones for the rest of the vector.
        if (ovf_q || sum[ACC_WIDTH]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum[ACC_WIDTH-1:0];
        end
`else
        acc_d = acc_q + ACC_WIDTH'(prod);
`endif
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state so they align with state_q.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        a_r_q[i] <= '0;
        b_r_q[i] <= '0;
      end
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DOT_SEQ_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      a_r_q       <= a_r_d;
      b_r_q       <= b_r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef DOT_SEQ_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = acc_q;
`ifdef DOT_SEQ_SAT_EN
  assign out_ovf   = ovf_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: a lossless-width instance and a 16-bit accumulator instance.
module tb_dot_product_sequencer;
  localparam int unsigned BW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned W0 = 18;
  localparam int unsigned W1 = 16;

  typedef logic [BW-1:0] vec_t [N-1:0];
  typedef struct {
    vec_t        va;
    vec_t        vb;
    logic [63:0] sum0;
    logic [63:0] sum1_sat;
    logic [63:0] sum1_wrap;
    logic        ovf1_sat;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  vec_t a_in;
  vec_t b_in;

  logic          in_ready0, out_valid0, out_ovf0, busy0;
  logic [W0-1:0] out_sum0;
  logic          in_ready1, out_valid1, out_ovf1, busy1;
  logic [W1-1:0] out_sum1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dot_product_sequencer #(.BIT_WIDTH(BW), .N(N)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a_in), .b(b_in), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(out_sum0), .out_ovf(out_ovf0), .busy(busy0)
  );

  dot_product_sequencer #(.BIT_WIDTH(BW), .N(N), .ACC_WIDTH(W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a_in), .b(b_in), .out_valid(out_valid1), .out_ready(out_ready),
    .out_sum(out_sum1), .out_ovf(out_ovf1), .busy(busy1)
  );

  // Reference model: plain integer arithmetic on the whole vector.
  function automatic logic [63:0] dot(input vec_t x, input vec_t y);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s += 64'(x[i]) * 64'(y[i]);
    return s;
  endfunction

  function automatic logic [63:0] exp1_sum(input logic [63:0] total);
`ifdef DOT_SEQ_SAT_EN
    return (total > 64'd65535) ? 64'd65535 : total;
`else
    return total & 64'hFFFF;
`endif
  endfunction

  function automatic logic exp1_ovf(input logic [63:0] total);
`ifdef DOT_SEQ_SAT_EN
    return total > 64'd65535;
`else
    return (total != total);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_in_ready"},  64'(in_ready0),  64'd1);
    check({pfx, "_out_valid"}, 64'(out_valid0), 64'd0);
    check({pfx, "_out_sum"},   64'(out_sum0),   64'd0);
    check({pfx, "_out_ovf"},   64'(out_ovf0),   64'd0);
    check({pfx, "_busy"},      64'(busy0),      64'd0);
    check({pfx, "_out_sum16"}, 64'(out_sum1),   64'd0);
  endtask

  task automatic check_result(input string pfx, input logic [63:0] e0, input logic [63:0] e1, input logic e1o);
    check({pfx, "_sum"},    64'(out_sum0), e0);
    check({pfx, "_ovf"},    64'(out_ovf0), 64'd0);
    check({pfx, "_sum16"},  64'(out_sum1), e1);
    check({pfx, "_ovf16"},  64'(out_ovf1), 64'(e1o));
  endtask

  task automatic wait_ready(input string pfx);
    int k;
    k = 0;
    while (!(in_ready0 && in_ready1) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check({pfx, "_ready_timeout"}, 64'(in_ready0), 64'd1);
  endtask

  // Offers one vector, lets it be accepted, and returns cycles from accept edge to out_valid.
  task automatic send_and_wait(input vec_t vx, input vec_t vy, output int lat);
    a_in = vx;
    b_in = vy;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume(input string pfx);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({pfx, "_post_valid"}, 64'(out_valid0), 64'd0);
    check({pfx, "_post_ready"}, 64'(in_ready0),  64'd1);
  endtask

  rec_t tbl [5];

  initial begin
    int lat;
    logic [63:0] tot;
    logic [63:0] e1;
    logic        e1o;
    vec_t vx, vy, v2x, v2y;
    vec_t bx [3];
    vec_t by [3];
    logic [63:0] btot [3];
    int acc_cyc [3];
    int issued, got;
    logic take;
    logic seen_valid;

    tbl[0] = '{va: '{8'd4, 8'd3, 8'd2, 8'd1}, vb: '{8'd8, 8'd7, 8'd6, 8'd5},
               sum0: 64'd70, sum1_sat: 64'd70, sum1_wrap: 64'd70, ovf1_sat: 1'b0};
    tbl[1] = '{va: '{8'd255, 8'd255, 8'd255, 8'd255}, vb: '{8'd255, 8'd255, 8'd255, 8'd255},
               sum0: 64'h3F804, sum1_sat: 64'hFFFF, sum1_wrap: 64'hF804, ovf1_sat: 1'b1};
    tbl[2] = '{va: '{8'd0, 8'd0, 8'd0, 8'd0}, vb: '{8'd255, 8'd255, 8'd255, 8'd255},
               sum0: 64'd0, sum1_sat: 64'd0, sum1_wrap: 64'd0, ovf1_sat: 1'b0};
    tbl[3] = '{va: '{8'd255, 8'd2, 8'd0, 8'd0}, vb: '{8'd255, 8'd255, 8'd0, 8'd0},
               sum0: 64'd65535, sum1_sat: 64'hFFFF, sum1_wrap: 64'hFFFF, ovf1_sat: 1'b0};
    tbl[4] = '{va: '{8'd255, 8'd0, 8'd1, 8'd128}, vb: '{8'd255, 8'd255, 8'd255, 8'd2},
               sum0: 64'd65536, sum1_sat: 64'hFFFF, sum1_wrap: 64'h0, ovf1_sat: 1'b1};

    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end

    rst_n = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      wait_ready($sformatf("tbl%0d", i));
      send_and_wait(tbl[i].va, tbl[i].vb, lat);
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(N));
`ifdef DOT_SEQ_SAT_EN
      e1 = tbl[i].sum1_sat;
      e1o = tbl[i].ovf1_sat;
`else
      e1 = tbl[i].sum1_wrap;
      e1o = 1'b0;
`endif
      check_result($sformatf("tbl%0d", i), tbl[i].sum0, e1, e1o);
      consume($sformatf("tbl%0d", i));
    end

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        vx[i] = BW'($urandom);
        vy[i] = BW'($urandom);
      end
      tot = dot(vx, vy);
      wait_ready($sformatf("rnd%0d", r));
      send_and_wait(vx, vy, lat);
      check($sformatf("rnd%0d_latency", r), 64'(lat), 64'(N));
      check_result($sformatf("rnd%0d", r), tot, exp1_sum(tot), exp1_ovf(tot));
      consume($sformatf("rnd%0d", r));
    end

    // Backpressure: second vector is offered throughout and operand ports change after acceptance.
    vx  = '{8'd40, 8'd30, 8'd20, 8'd10};
    vy  = '{8'd1, 8'd1, 8'd1, 8'd1};
    v2x = '{8'd9, 8'd9, 8'd9, 8'd9};
    v2y = '{8'd9, 8'd9, 8'd9, 8'd9};
    wait_ready("bp");
    a_in = vx;
    b_in = vy;
    in_valid = 1'b1;
    tick();
    check("bp_busy_after_accept", 64'(busy0), 64'd1);
    a_in = v2x;
    b_in = v2y;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(N));
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bp_hold%0d_sum", s), 64'(out_sum0), 64'd100);
      check($sformatf("bp_hold%0d_valid", s), 64'(out_valid0), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", s), 64'(in_ready0), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_consumed_valid", 64'(out_valid0), 64'd0);
    check("bp_consumed_in_ready", 64'(in_ready0), 64'd1);
    tick();
    check("bp_second_accept_in_ready", 64'(in_ready0), 64'd0);
    check("bp_second_accept_busy", 64'(busy0), 64'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 20) begin
      tick();
      lat++;
    end
    check("bp2_latency", 64'(lat), 64'(N));
    tot = dot(v2x, v2y);
    check_result("bp2", tot, exp1_sum(tot), exp1_ovf(tot));
    consume("bp2");

    // Back-to-back: in_valid and out_ready held high across three vectors.
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) begin
        bx[v][i] = BW'($urandom);
        by[v][i] = BW'($urandom);
      end
      btot[v] = dot(bx[v], by[v]);
      acc_cyc[v] = -1;
    end
    wait_ready("b2b");
    out_ready = 1'b1;
    a_in = bx[0];
    b_in = by[0];
    in_valid = 1'b1;
    issued = 0;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      take = in_ready0 && in_valid;
      if (out_valid0) begin
        check_result($sformatf("b2b%0d", got), btot[got], exp1_sum(btot[got]), exp1_ovf(btot[got]));
        got++;
      end
      if (take) acc_cyc[issued] = cyc;
      tick();
      if (take) begin
        issued++;
        if (issued < 3) begin
          a_in = bx[issued];
          b_in = by[issued];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b_results", 64'(got), 64'd3);
    check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'(N + 2));
    check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'(N + 2));

    // Reset two cycles into MAC discards the vector.
    wait_ready("rst");
    a_in = tbl[1].va;
    b_in = tbl[1].vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    tick();
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      tick();
      if (out_valid0 || out_valid1) seen_valid = 1'b1;
    end
    check("rst_no_valid", 64'(seen_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready0), 64'd1);
    vx = '{8'd2, 8'd2, 8'd2, 8'd2};
    vy = '{8'd3, 8'd3, 8'd3, 8'd3};
    wait_ready("rst_next");
    send_and_wait(vx, vy, lat);
    check("rst_next_latency", 64'(lat), 64'(N));
    check_result("rst_next", 64'd24, 64'd24, 1'b0);
    consume("rst_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dot_product_sequencer.md
# dot_product_sequencer

- Sequences one shared BIT_WIDTH x BIT_WIDTH multiplier and one accumulator over the N lane pairs of a vector operand.
- Computes the unsigned dot product sum(a[i]*b[i]) for i = 0..N-1, one lane per cycle.
- Sits between a vector producer and a result consumer, with valid/ready handshakes on both sides.
- Replaces N parallel multipliers and an adder tree with N cycles of time-multiplexed MAC.

## Interface

Parameters:
- BIT_WIDTH, 8, width of each lane element.
- N, 4, lanes per vector (N >= 2).
- ACC_WIDTH, 2*BIT_WIDTH+$clog2(N), accumulator and result width; may be set smaller than the lossless width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer offers a vector.
- in_ready  output  1  block accepts a vector; high only in IDLE.
- a  input  [BIT_WIDTH-1:0] x N (unpacked [N-1:0])  lane operands A.
- b  input  [BIT_WIDTH-1:0] x N (unpacked [N-1:0])  lane operands B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_sum  output  ACC_WIDTH  dot product result.
- out_ovf  output  1  accumulation overflowed ACC_WIDTH (saturation build only).
- busy  output  1  high in MAC or DONE.

## Operation

- FSM states: IDLE, MAC, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: register a[], b[] into operand banks; acc<=0, idx<=0, ovf<=0; go to MAC.
  - Input ports are not sampled after acceptance.
- **MAC**
  - Each cycle: acc <= acc + a_r[idx]*b_r[idx]; the product is full 2*BIT_WIDTH unsigned, zero-extended to the adder width; idx <= idx+1.
  - When idx==N-1, the final lane is accumulated and the FSM goes to DONE.
- **DONE**
  - out_valid=1; out_sum=acc; out_ovf=ovf.
  - On out_ready: go to IDLE.
  - out_sum and out_ovf are held stable while out_valid && !out_ready.
- No lane skipping and no early termination; a zero operand still costs one cycle.
- Arithmetic is unsigned throughout. The adder is ACC_WIDTH+1 bits wide, and its carry-out is the overflow indication.
- in_ready is 0 during MAC and DONE. A vector presented then is not accepted and must be held by the producer.
- in_valid with in_ready=0 has no effect.
- Reset asserted in any state:
  - Immediately returns the FSM to IDLE.
  - Discards the in-flight vector.
  - Never produces out_valid for it.

## Timing

- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - idx=0, acc=0; operand banks are cleared to 0.
- Accept at edge E0. Lane i is accumulated at edge E(i+1).
- out_valid rises after edge EN, i.e. N cycles after acceptance.
- Earliest consume is at edge E(N+1), which returns the FSM to IDLE. Earliest next accept is at E(N+2).
- Minimum transaction period is N+2 cycles.
- out_valid, out_sum, out_ovf, busy and in_ready are driven from registered state; there are no combinational input-to-output paths.
- out_ready low stalls DONE indefinitely with no loss.

## Configuration

- Macro: DOT_SEQ_SAT_EN.
- **Defined:**
  - When a carry-out occurs, acc clamps to all-ones (2^ACC_WIDTH-1) and remains there for the rest of the vector.
  - ovf is set and is sticky until the next acceptance.
  - out_ovf reports ovf in DONE.
- **Undefined:**
  - acc wraps modulo 2^ACC_WIDTH.
  - out_ovf is tied to 0.
  - No saturation logic is generated.
- With the default ACC_WIDTH, overflow is impossible and both builds give identical results.

## Test plan

- Basic: N=4, BIT_WIDTH=8, a={1,2,3,4}, b={5,6,7,8} -> out_sum=70, out_ovf=0, out_valid rises 4 cycles after accept.
- Max lossless: all lanes 255, default ACC_WIDTH=18 -> out_sum=260100 (0x3F804), out_ovf=0.
- Overflow: all lanes 255, ACC_WIDTH=16 -> with DOT_SEQ_SAT_EN: out_sum=0xFFFF, out_ovf=1; without: out_sum=0xF804, out_ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and a new vector offered -> out_sum is stable, in_ready=0, and the second vector is accepted only 1 cycle after out_ready handshake.
- Back-to-back: in_valid and out_ready held high over 3 vectors -> accepts spaced exactly N+2=6 cycles apart; results in order.
- Reset mid-MAC: assert rst_n=0 two cycles after accept -> all outputs at reset values immediately, no out_valid. Next vector {2,2,2,2}x{3,3,3,3} -> out_sum=24.
